// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - shared states and constants for the run sequencer
package run_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_RUN,
        ST_HALT
    } run_state_t;

    localparam logic [8:0] HALT_OPCODE = 9'b101100100;
    localparam int         MEM_AW      = 8;
    localparam int         MEM_DW      = 8;

endpackage

// File: rtl/mem_port_mux.sv
// rtl/mem_port_mux.sv - data-memory write port select between loader and core
module mem_port_mux
    import run_seq_pkg::*;
(
    input  logic              i_sel_loader,
    input  logic              i_sel_core,
    input  logic [MEM_AW-1:0] i_ld_addr,
    input  logic [MEM_DW-1:0] i_ld_data,
    input  logic              i_ld_we,
    input  logic [MEM_AW-1:0] i_core_addr,
    input  logic [MEM_DW-1:0] i_core_wdata,
    input  logic              i_core_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [MEM_DW-1:0] o_mem_wdata,
    output logic              o_mem_we
);

    // Neither owner selected: the port is driven fully idle, not just write-disabled.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        if (i_sel_loader) begin
            o_mem_addr  = i_ld_addr;
            o_mem_wdata = i_ld_data;
            o_mem_we    = i_ld_we;
        end else if (i_sel_core) begin
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
            o_mem_we    = i_core_we;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - preload, PC clear, run and halt/watchdog control for the core
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter logic [8:0] HALT_INSTR = HALT_OPCODE,
    parameter int         WATCHDOG   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        instr,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [MEM_DW-1:0] ld_data,
    output logic              ld_ready,
    input  logic [MEM_AW-1:0] core_addr,
    input  logic [MEM_DW-1:0] core_wdata,
    input  logic              core_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_we,
    output logic              core_pc_clr,
    output logic              core_run,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       cycle_count
);

    localparam logic [15:0] WD_LAST = 16'(WATCHDOG - 1);

    run_state_t  r_state;
    logic        r_done;
    logic        r_timeout;
    logic [15:0] r_cycle_count;

    logic w_in_load;
    logic w_in_run;
    logic w_is_halt;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_in_run  = (r_state == ST_RUN);
    assign w_is_halt = (instr == HALT_INSTR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (ld_valid && ld_last) r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_cycle_count <= '0;
                    r_state       <= ST_RUN;
                end
                ST_RUN: begin
                    // The count covers the halt-detection cycle too; halt beats the watchdog.
                    r_cycle_count <= r_cycle_count + 16'd1;
                    if (w_is_halt) begin
                        r_done  <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (r_cycle_count == WD_LAST) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_state   <= ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ld_ready    = w_in_load;
    assign core_pc_clr = (r_state == ST_CLEAR);
    assign core_run    = w_in_run && !w_is_halt;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

    mem_port_mux u_mem_port_mux (
        .i_sel_loader (w_in_load),
        .i_sel_core   (w_in_run),
        .i_ld_addr    (ld_addr),
        .i_ld_data    (ld_data),
        .i_ld_we      (ld_valid),
        .i_core_addr  (core_addr),
        .i_core_wdata (core_wdata),
        .i_core_we    (core_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized bench for run_sequencer against a behavioural model
module tb_run_sequencer;

    localparam logic [8:0] HALT = 9'b101100100;
    localparam int         WD   = 8;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_CLEAR = 2;
    localparam int M_RUN   = 3;
    localparam int M_HALT  = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        start      = 1'b0;
    logic [8:0]  instr      = '0;
    logic        ld_valid   = 1'b0;
    logic        ld_last    = 1'b0;
    logic [7:0]  ld_addr    = '0;
    logic [7:0]  ld_data    = '0;
    logic [7:0]  core_addr  = '0;
    logic [7:0]  core_wdata = '0;
    logic        core_we    = 1'b0;
    logic        ld_ready;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        core_pc_clr;
    logic        core_run;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode = M_IDLE;
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit m_to   = 1'b0;

    int load_writes = 0;
    int clr_cycles  = 0;

    run_sequencer #(.HALT_INSTR(HALT), .WATCHDOG(WD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_last     (ld_last),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_we     (core_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .core_pc_clr (core_pc_clr),
        .core_run    (core_run),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase of the run plus the result registers, advanced per spec rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_done = 1'b0;
            m_to   = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_LOAD;
                M_LOAD:  if (ld_valid && ld_last) m_mode = M_CLEAR;
                M_CLEAR: begin m_cnt = 0; m_mode = M_RUN; end
                M_RUN: begin
                    m_cnt = m_cnt + 1;
                    if (instr == HALT) begin
                        m_done = 1'b1; m_mode = M_HALT;
                    end else if (m_cnt == WD) begin
                        m_done = 1'b1; m_to = 1'b1; m_mode = M_HALT;
                    end
                end
                default: if (start) begin m_done = 1'b0; m_to = 1'b0; m_mode = M_LOAD; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("ld_ready", 32'(ld_ready), 32'(m_mode == M_LOAD));
            chk("mem_we", 32'(mem_we),
                32'((m_mode == M_LOAD && ld_valid) || (m_mode == M_RUN && core_we)));
            if (m_mode == M_LOAD) begin
                if (ld_valid) begin
                    chk("mem_addr_ld", 32'(mem_addr), 32'(ld_addr));
                    chk("mem_wdata_ld", 32'(mem_wdata), 32'(ld_data));
                end
            end else if (m_mode == M_RUN) begin
                chk("mem_addr_core", 32'(mem_addr), 32'(core_addr));
                chk("mem_wdata_core", 32'(mem_wdata), 32'(core_wdata));
            end else begin
                chk("mem_addr_idle", 32'(mem_addr), 32'd0);
                chk("mem_wdata_idle", 32'(mem_wdata), 32'd0);
            end
            chk("core_pc_clr", 32'(core_pc_clr), 32'(m_mode == M_CLEAR));
            chk("core_run", 32'(core_run), 32'(m_mode == M_RUN && instr != HALT));
            chk("done", 32'(done), 32'(m_done));
            chk("timeout", 32'(timeout), 32'(m_to));
            chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
            if (m_mode == M_LOAD && mem_we) load_writes++;
            if (core_pc_clr) clr_cycles++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] rand_instr();
        logic [8:0] v;
        v = 9'($urandom);
        if (v == HALT) v = v ^ 9'd1;
        return v;
    endfunction

    task automatic noise(input bit core_hold);
        core_we    = core_hold ? 1'b1 : 1'($urandom);
        core_addr  = 8'($urandom);
        core_wdata = 8'($urandom);
    endtask

    task automatic do_run(input int nbeats, input int halt_at, input bit fixed,
                          input bit core_hold, input bit start_in_run);
        int gaps;
        noise(core_hold);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("enter_load_ready", 32'(ld_ready), 32'd1);
        chk("enter_load_done", 32'(done), 32'd0);
        chk("enter_load_timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                ld_valid = 1'b0;
                ld_last  = 1'($urandom);
                ld_addr  = 8'($urandom);
                noise(core_hold);
                step();
            end
            ld_valid = 1'b1;
            ld_last  = (i == nbeats - 1);
            ld_addr  = fixed ? 8'(i) : 8'($urandom);
            ld_data  = fixed ? 8'((i + 1) * 17) : 8'($urandom);
            noise(core_hold);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        noise(core_hold);
        step();
        for (int c = 1; c <= WD; c++) begin
            instr = (c == halt_at) ? HALT : rand_instr();
            noise(core_hold);
            if (start_in_run) start = 1'b1;
            step();
            if (c == halt_at) break;
        end
        start = 1'b0;
        repeat (2) begin
            instr = rand_instr();
            noise(core_hold);
            ld_valid = 1'($urandom);
            step();
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_core_pc_clr", 32'(core_pc_clr), 32'd0);
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);
        reset = 1'b0;

        repeat (3) begin
            ld_valid = 1'b1;
            ld_addr  = 8'($urandom);
            noise(1'b1);
            step();
        end
        ld_valid = 1'b0;

        load_writes = 0;
        clr_cycles  = 0;
        do_run(3, 5, 1'b1, 1'b0, 1'b0);
        chk("t1_load_writes", 32'(load_writes), 32'd3);
        chk("t1_clr_cycles", 32'(clr_cycles), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_timeout", 32'(timeout), 32'd0);
        chk("t1_count", 32'(cycle_count), 32'd5);

        do_run(2, 0, 1'b0, 1'b0, 1'b0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_timeout", 32'(timeout), 32'd1);
        chk("t2_count", 32'(cycle_count), 32'd8);
        chk("t2_core_run", 32'(core_run), 32'd0);

        do_run(1, 1, 1'b0, 1'b0, 1'b0);
        chk("t3_count", 32'(cycle_count), 32'd1);
        chk("t3_timeout", 32'(timeout), 32'd0);

        do_run(2, 4, 1'b0, 1'b1, 1'b0);
        chk("t4_halt_mem_we", 32'(mem_we), 32'd0);

        do_run(1, 8, 1'b0, 1'b0, 1'b0);
        chk("t5_tie_done", 32'(done), 32'd1);
        chk("t5_tie_timeout", 32'(timeout), 32'd0);
        chk("t5_tie_count", 32'(cycle_count), 32'd8);

        start = 1'b1;
        step();
        start    = 1'b0;
        ld_valid = 1'b1; ld_last = 1'b0; ld_addr = 8'h10; ld_data = 8'hA5;
        step();
        ld_addr = 8'h11; ld_data = 8'h5A;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_ld_ready", 32'(ld_ready), 32'd0);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_mem_addr", 32'(mem_addr), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_count", 32'(cycle_count), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ld_valid = 1'b0;
        step();
        do_run(4, 3, 1'b0, 1'b0, 1'b0);
        chk("t6_fresh_count", 32'(cycle_count), 32'd3);

        do_run(2, 0, 1'b0, 1'b0, 1'b1);
        chk("t7_timeout", 32'(timeout), 32'd1);
        do_run(1, 2, 1'b0, 1'b0, 1'b0);
        chk("t7_count", 32'(cycle_count), 32'd2);

        for (int r = 0; r < 20; r++) begin
            do_run(int'($urandom_range(1, 5)), int'($urandom_range(0, 10)),
                   1'b0, 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
